// File: rtl/cpu_pkg.sv
// Shared processor constants: instruction width and opcode field layout
// used by fetch and decode.
package cpu_pkg;

  localparam int unsigned INSTR_WIDTH = 20;
  localparam int unsigned OPC_MSB     = 19;
  localparam int unsigned OPC_LSB     = 16;

  typedef logic [OPC_MSB-OPC_LSB:0] opcode_t;

  localparam opcode_t OPC_STORE = 4'b1100;
  localparam opcode_t OPC_HALT  = 4'b1111;

  function automatic logic is_halt(input opcode_t opcode);
    return opcode == OPC_HALT;
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction-memory read port, decode-side handshake and
// branch redirect, grouped for the fetch stage (master) and its environment.
interface instruction_fetch_if #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned INSTR_WIDTH = cpu_pkg::INSTR_WIDTH
);

  logic                   imem_req;
  logic [ADDR_WIDTH-1:0]  imem_addr;
  logic [INSTR_WIDTH-1:0] imem_rdata;
  logic                   stall;
  logic                   redirect;
  logic [ADDR_WIDTH-1:0]  redirect_pc;
  logic [INSTR_WIDTH-1:0] instruction;
  logic                   instr_valid;
  logic [ADDR_WIDTH-1:0]  instr_pc;
  logic                   halted;

  modport master (
    output imem_req, imem_addr, instruction, instr_valid, instr_pc, halted,
    input  imem_rdata, stall, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instruction, instr_valid, instr_pc, halted,
    output imem_rdata, stall, redirect, redirect_pc
  );

endinterface

// File: rtl/fetch_queue.sv
// Two-entry FIFO holding fetched {instruction, pc}; slot0 is always the head
// so the output comes straight from a register. Flush overrides push/pop.
module fetch_queue #(
  parameter int unsigned WIDTH = 28
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] slot0;
  logic [WIDTH-1:0] slot1;
  logic             do_pop;

  assign head   = slot0;
  assign do_pop = pop && (count != 2'd0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot0 <= '0;
      slot1 <= '0;
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      unique case ({push, do_pop})
        2'b10: begin
          if (count == 2'd0) slot0 <= data;
          else               slot1 <= data;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        // simultaneous push/pop: the new word lands behind whatever survives
        2'b11: begin
          if (count == 2'd2) begin
            slot0 <= slot1;
            slot1 <= data;
          end else begin
            slot0 <= data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC generation, credit-limited requests to a 1-cycle
// instruction memory, 2-entry buffering toward decode, redirect and HALT.
module instruction_fetch #(
  parameter int unsigned          ADDR_WIDTH  = 8,
  parameter int unsigned          INSTR_WIDTH = cpu_pkg::INSTR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                 clock,
  input  logic                 reset,
  instruction_fetch_if.master  bus
);

  import cpu_pkg::*;

  localparam int unsigned QW = INSTR_WIDTH + ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] inflight_pc;
  logic                  inflight;
  logic                  halted;
  logic [1:0]            count;
  logic [QW-1:0]         head;
  logic                  pop;
  logic                  push;
  logic                  issue;
  logic                  halt_seen;
  logic [2:0]            occupancy;

  // Queue slots plus the outstanding request never exceed two, so a
  // response always has room when it lands.
  always_comb begin
    pop       = bus.instr_valid && !bus.stall;
    push      = inflight && !bus.redirect && !halted;
    halt_seen = push && is_halt(bus.imem_rdata[OPC_MSB:OPC_LSB]);
    occupancy = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
    issue     = !halted && (occupancy < 3'd2);
  end

  assign bus.imem_req    = !reset && (bus.redirect || issue);
  assign bus.imem_addr   = bus.redirect ? bus.redirect_pc : pc;
  assign bus.instr_valid = (count != 2'd0);
  assign bus.instruction = head[QW-1:ADDR_WIDTH];
  assign bus.instr_pc    = head[ADDR_WIDTH-1:0];
  assign bus.halted      = halted;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      inflight_pc <= '0;
      inflight    <= 1'b0;
      halted      <= 1'b0;
    end else if (bus.redirect) begin
      pc          <= bus.redirect_pc + ADDR_WIDTH'(1);
      inflight_pc <= bus.redirect_pc;
      inflight    <= 1'b1;
      halted      <= 1'b0;
    end else begin
      if (issue) begin
        inflight_pc <= pc;
        pc          <= pc + ADDR_WIDTH'(1);
        inflight    <= 1'b1;
      end else begin
        inflight    <= 1'b0;
      end
      if (halt_seen) halted <= 1'b1;
    end
  end

  fetch_queue #(
    .WIDTH (QW)
  ) queue (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect),
    .data  ({bus.imem_rdata, inflight_pc}),
    .head  (head),
    .count (count)
  );

  credit_bound: assert property (@(posedge clock) disable iff (reset)
    ({1'b0, count} + {2'b0, inflight}) <= 3'd2);

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios with literal expectations,
// then randomized stall/redirect/reset traffic against a queue-based model.
module tb_instruction_fetch;

  localparam int unsigned AW = 8;
  localparam int unsigned IW = 20;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  instruction_fetch_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) bus ();
  instruction_fetch_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) wbus ();

  instruction_fetch #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .RESET_PC(8'h00)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  instruction_fetch #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .RESET_PC(8'hFE)) dut_wrap (
    .clock (clock),
    .reset (reset),
    .bus   (wbus)
  );

  // Synchronous instruction memory; unrequested cycles return junk.
  logic [IW-1:0] imem [256];

  always @(posedge clock) begin
    bus.imem_rdata  <= bus.imem_req  ? imem[bus.imem_addr]  : IW'($urandom);
    wbus.imem_rdata <= wbus.imem_req ? imem[wbus.imem_addr] : IW'($urandom);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: the delivered stream is a FIFO of fetched words; at most
  // one read is outstanding and its data joins the FIFO one cycle later.
  typedef struct packed {
    logic [IW-1:0] word;
    logic [AW-1:0] pc;
  } ent_t;

  ent_t          mq[$];
  logic [AW-1:0] m_pc = '0;
  logic [AW-1:0] m_ipc = '0;
  bit            m_inflight = 1'b0;
  bit            m_halted = 1'b0;

  function automatic bit model_pop();
    return (mq.size() != 0) && !bus.stall;
  endfunction

  function automatic bit model_req();
    int occ;
    occ = mq.size() + int'(m_inflight) - int'(model_pop());
    return bus.redirect || (!m_halted && occ < 2);
  endfunction

  task automatic model_step();
    ent_t e;
    bit   got_halt;
    bit   req;
    got_halt = 1'b0;
    if (bus.redirect) begin
      mq.delete();
      m_halted   = 1'b0;
      m_inflight = 1'b1;
      m_ipc      = bus.redirect_pc;
      m_pc       = bus.redirect_pc + 8'd1;
    end else begin
      req = model_req();
      if (model_pop()) void'(mq.pop_front());
      if (m_inflight && !m_halted) begin
        e.word = imem[m_ipc];
        e.pc   = m_ipc;
        mq.push_back(e);
        got_halt = (e.word[19:16] == 4'hF);
      end
      if (req) begin
        m_ipc      = m_pc;
        m_pc       = m_pc + 8'd1;
        m_inflight = 1'b1;
      end else begin
        m_inflight = 1'b0;
      end
      if (got_halt) m_halted = 1'b1;
    end
  endtask

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_pc       = '0;
      m_ipc      = '0;
      m_inflight = 1'b0;
      m_halted   = 1'b0;
    end else begin
      model_step();
    end
  end

  // Cycle-by-cycle comparison of the main DUT against the model.
  always @(negedge clock) begin
    bit exp_req;
    if (reset) begin
      chk("rst_valid", 32'(bus.instr_valid), 32'd0);
      chk("rst_req",   32'(bus.imem_req),    32'd0);
      chk("rst_instr", 32'(bus.instruction), 32'd0);
      chk("rst_pc",    32'(bus.instr_pc),    32'd0);
      chk("rst_halt",  32'(bus.halted),      32'd0);
    end else begin
      chk("valid", 32'(bus.instr_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("instr", 32'(bus.instruction), 32'(mq[0].word));
        chk("pc",    32'(bus.instr_pc),    32'(mq[0].pc));
      end
      chk("halted", 32'(bus.halted), 32'(m_halted));
      exp_req = model_req();
      chk("req", 32'(bus.imem_req), 32'(exp_req));
      if (exp_req)
        chk("addr", 32'(bus.imem_addr), 32'(bus.redirect ? bus.redirect_pc : m_pc));
    end
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic pin_head(input string name, input logic [IW-1:0] word, input logic [AW-1:0] pc);
    chk({name, "_valid"}, 32'(bus.instr_valid), 32'd1);
    chk({name, "_instr"}, 32'(bus.instruction), 32'(word));
    chk({name, "_pc"},    32'(bus.instr_pc),    32'(pc));
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    bus.stall = 1'b0;  bus.redirect = 1'b0;  bus.redirect_pc = '0;
    wbus.stall = 1'b0; wbus.redirect = 1'b0; wbus.redirect_pc = '0;
    for (int i = 0; i < 256; i++) imem[i] = {4'(i % 15), 16'(i * 257)};
    imem[0] = 20'h11111; imem[1] = 20'h22222; imem[2] = 20'h33333; imem[3] = 20'h44444;
    imem[8'h40] = 20'hABCDE;

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Straight-line fetch, with the wrap instance running alongside
    sample();
    chk("c0_req",  32'(bus.imem_req),     32'd1);
    chk("c0_addr", 32'(bus.imem_addr),    32'd0);
    chk("c0_valid",32'(bus.instr_valid),  32'd0);
    chk("w0_addr", 32'(wbus.imem_addr),   32'hFE);
    next_cycle(); sample();
    chk("c1_valid",32'(bus.instr_valid),  32'd0);
    chk("c1_addr", 32'(bus.imem_addr),    32'd1);
    next_cycle(); sample();
    pin_head("c2", 20'h11111, 8'd0);
    chk("w2_pc", 32'(wbus.instr_pc), 32'hFE);

    // Stall four cycles while 0x22222 is presented
    next_cycle(); bus.stall = 1'b1; sample();
    pin_head("st0", 20'h22222, 8'd1);
    chk("st0_req", 32'(bus.imem_req), 32'd0);
    chk("w3_pc", 32'(wbus.instr_pc), 32'hFF);
    for (int k = 1; k < 4; k++) begin
      next_cycle(); sample();
      pin_head("st", 20'h22222, 8'd1);
      chk("st_req", 32'(bus.imem_req), 32'd0);
      if (k == 1) chk("w4_pc", 32'(wbus.instr_pc), 32'h00);
      if (k == 2) chk("w5_pc", 32'(wbus.instr_pc), 32'h01);
    end
    next_cycle(); bus.stall = 1'b0; sample();
    pin_head("rel", 20'h22222, 8'd1);
    chk("rel_addr", 32'(bus.imem_addr), 32'd3);
    next_cycle(); sample(); pin_head("c8", 20'h33333, 8'd2);
    next_cycle(); sample(); pin_head("c9", 20'h44444, 8'd3);

    // Redirect with a full queue under stall
    next_cycle(); bus.stall = 1'b1; sample();
    next_cycle(); bus.redirect = 1'b1; bus.redirect_pc = 8'h40; sample();
    chk("rd_req",  32'(bus.imem_req),  32'd1);
    chk("rd_addr", 32'(bus.imem_addr), 32'h40);
    chk("rd_head", 32'(bus.instr_pc),  32'd4);
    next_cycle(); bus.redirect = 1'b0; bus.stall = 1'b0; sample();
    chk("rd1_valid", 32'(bus.instr_valid), 32'd0);
    next_cycle(); sample(); pin_head("rd2", 20'hABCDE, 8'h40);

    // HALT at address 2
    next_cycle(); imem[2] = 20'hF0000; bus.redirect = 1'b1; bus.redirect_pc = 8'h00; sample();
    next_cycle(); bus.redirect = 1'b0; sample();
    next_cycle(); sample(); pin_head("h2", 20'h11111, 8'd0);
    next_cycle(); sample(); pin_head("h3", 20'h22222, 8'd1);
    next_cycle(); sample(); pin_head("h4", 20'hF0000, 8'd2);
    chk("h4_halted", 32'(bus.halted),   32'd1);
    chk("h4_req",    32'(bus.imem_req), 32'd0);
    for (int k = 0; k < 4; k++) begin
      next_cycle(); sample();
      chk("hh_req",   32'(bus.imem_req),    32'd0);
      chk("hh_valid", 32'(bus.instr_valid), 32'd0);
    end
    next_cycle(); imem[2] = 20'h33333; bus.redirect = 1'b1; sample();
    next_cycle(); bus.redirect = 1'b0; sample();
    chk("hr_halted", 32'(bus.halted), 32'd0);
    next_cycle(); sample(); pin_head("hr2", 20'h11111, 8'd0);
    next_cycle(); sample(); pin_head("hr3", 20'h22222, 8'd1);
    next_cycle(); sample(); pin_head("hr4", 20'h33333, 8'd2);

    // Asynchronous reset with work queued and in flight
    next_cycle(); bus.stall = 1'b1; sample();
    next_cycle(); sample();
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    chk("ar_valid", 32'(bus.instr_valid), 32'd0);
    chk("ar_instr", 32'(bus.instruction), 32'd0);
    chk("ar_pc",    32'(bus.instr_pc),    32'd0);
    chk("ar_req",   32'(bus.imem_req),    32'd0);
    next_cycle(); next_cycle();
    reset = 1'b0; bus.stall = 1'b0;
    sample();
    chk("ar0_addr",  32'(bus.imem_addr),   32'd0);
    chk("ar0_valid", 32'(bus.instr_valid), 32'd0);
    next_cycle(); sample();
    next_cycle(); sample(); pin_head("ar2", 20'h11111, 8'd0);

    // Randomized traffic
    next_cycle(); reset = 1'b1;
    for (int i = 0; i < 256; i++) imem[i] = IW'($urandom);
    next_cycle(); reset = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      next_cycle();
      bus.stall       = ($urandom_range(0, 99) < 35);
      bus.redirect    = ($urandom_range(0, 99) < 6);
      bus.redirect_pc = AW'($urandom);
      if ($urandom_range(0, 399) == 0) begin
        #2 reset = 1'b1;
        next_cycle();
        reset = 1'b0;
      end
    end

    next_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
